// File: rtl/mtm_alu_deser_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mtm_alu_deser_param
//  Purpose  : Serial-frame deserializer for the mtm ALU. Collects 2*NB data
//             frames (operand B then operand A, MSB-first) plus one command
//             frame. Validates the frame count, stop bits, CRC4 and opcode,
//             and hands one record to the ALU core through a one-entry
//             ready/valid output register.
//  Ports    : clk            - system clock, rising edge
//             rst            - asynchronous reset, active high
//             sin            - serial input, idles high, 1 bit per clk
//             out_valid      - output record present
//             out_ready      - core accepts the record
//             out_b, out_a   - operands B and A (DATA_W bits each)
//             out_op         - 3-bit opcode
//             out_is_err     - record is an error report
//             out_err_flags  - 100100 DATA, 010010 CRC, 001001 OP, 0 = ok
//             overrun        - 1-cycle pulse when a record is dropped
//  Revision : 1.0 - initial release
// ============================================================================
module mtm_alu_deser_param #(
    parameter int          DATA_W    = 32,
    parameter logic [7:0]  VALID_OPS = 8'b0011_0011
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_a,
    output logic [2:0]        out_op,
    output logic              out_is_err,
    output logic [5:0]        out_err_flags,
    output logic              overrun
);

    localparam int NB    = DATA_W / 8;
    localparam int CNT_W = $clog2(2 * NB + 2);

    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(2 * NB);
    localparam logic [CNT_W-1:0] c_cnt_nb   = CNT_W'(NB);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_zero = '0;

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_type    = 3'd1;
    localparam logic [2:0] c_st_payload = 3'd2;
    localparam logic [2:0] c_st_stop    = 3'd3;
    localparam logic [2:0] c_st_break   = 3'd4;

    localparam logic [5:0] c_flags_data = 6'b100100;
    localparam logic [5:0] c_flags_crc  = 6'b010010;
    localparam logic [5:0] c_flags_op   = 6'b001001;
    localparam logic [5:0] c_flags_none = 6'b000000;

    // One serial step of CRC4 with polynomial x^4 + x + 1.
    function automatic logic [3:0] f_crc_step(input logic [3:0] c, input logic d);
        logic fb;
        fb = c[3] ^ d;
        return {c[2], c[1], c[0] ^ fb, fb};
    endfunction

    // ------------------------------------------------------------------
    // Receive-side state
    // ------------------------------------------------------------------
    logic [2:0]        r_state;
    logic [2:0]        r_bit_cnt;
    logic              r_is_cmd;
    logic [7:0]        r_byte;
    logic [CNT_W-1:0]  r_byte_cnt;
    logic [3:0]        r_crc;
    logic              r_discard;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_a;

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_b;
    logic [DATA_W-1:0] r_out_a;
    logic [2:0]        r_out_op;
    logic              r_out_is_err;
    logic [5:0]        r_out_flags;
    logic              r_overrun;

    // ------------------------------------------------------------------
    // Frame-end decode (all qualified by the stop-bit cycle)
    // ------------------------------------------------------------------
    logic              w_in_stop;
    logic              w_frame_err;
    logic              w_data_done;
    logic              w_cmd_done;
    logic              w_cnt_full;
    logic              w_extra;
    logic              w_data_store;
    logic              w_cmd_emit;
    logic [2:0]        w_cmd_op;
    logic [3:0]        w_cmd_crc;
    logic [3:0]        w_crc_final;
    logic              w_cnt_bad;
    logic              w_crc_bad;
    logic              w_op_bad;
    logic              w_rec_valid;
    logic              w_rec_is_err;
    logic [5:0]        w_rec_flags;
    logic              w_load;
    logic [DATA_W+7:0] w_b_shift;
    logic [DATA_W+7:0] w_a_shift;

    assign w_in_stop    = (r_state == c_st_stop);
    assign w_frame_err  = w_in_stop & ~sin;
    assign w_data_done  = w_in_stop & sin & ~r_is_cmd;
    assign w_cmd_done   = w_in_stop & sin & r_is_cmd;
    assign w_cnt_full   = (r_byte_cnt == c_cnt_full);
    // A data frame beyond the 2*NB expected ones poisons the packet.
    assign w_extra      = w_data_done & ~r_discard & w_cnt_full;
    assign w_data_store = w_data_done & ~r_discard & ~w_cnt_full;
    // A cmd frame that closes a discarded packet is swallowed silently.
    assign w_cmd_emit   = w_cmd_done & ~r_discard;

    assign w_cmd_op  = r_byte[6:4];
    assign w_cmd_crc = r_byte[3:0];

    // The CRC covers the operand bits, then a constant 1, then the op bits.
    assign w_crc_final = f_crc_step(f_crc_step(f_crc_step(f_crc_step(
                             r_crc, 1'b1), w_cmd_op[2]), w_cmd_op[1]), w_cmd_op[0]);

    assign w_cnt_bad = ~w_cnt_full;
    assign w_crc_bad = (w_crc_final != w_cmd_crc);
    assign w_op_bad  = ~VALID_OPS[w_cmd_op];

    assign w_rec_valid = w_cmd_emit | w_extra | w_frame_err;

    // Extra-frame and framing errors fall through to the DATA default.
    always_comb begin
        w_rec_is_err = 1'b1;
        w_rec_flags  = c_flags_data;
        if (w_cmd_emit && !w_cnt_bad) begin
            if (w_crc_bad) begin
                w_rec_flags = c_flags_crc;
            end else if (w_op_bad) begin
                w_rec_flags = c_flags_op;
            end else begin
                w_rec_is_err = 1'b0;
                w_rec_flags  = c_flags_none;
            end
        end
    end

    assign w_b_shift = {r_b, r_byte};
    assign w_a_shift = {r_a, r_byte};

    // ------------------------------------------------------------------
    // Frame state machine and packet assembly
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_bit_cnt  <= 3'd0;
            r_is_cmd   <= 1'b0;
            r_byte     <= 8'd0;
            r_byte_cnt <= c_cnt_zero;
            r_crc      <= 4'd0;
            r_discard  <= 1'b0;
            r_b        <= '0;
            r_a        <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (!sin) begin
                        r_state <= c_st_type;
                    end
                end
                c_st_type: begin
                    r_is_cmd  <= sin;
                    r_bit_cnt <= 3'd0;
                    r_state   <= c_st_payload;
                end
                c_st_payload: begin
                    r_byte    <= {r_byte[6:0], sin};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (!r_is_cmd && !r_discard) begin
                        r_crc <= f_crc_step(r_crc, sin);
                    end
                    if (r_bit_cnt == 3'd7) begin
                        r_state <= c_st_stop;
                    end
                end
                c_st_stop: begin
                    r_state <= sin ? c_st_idle : c_st_break;
                end
                c_st_break: begin
                    // Wait for the line to return high before hunting a start bit.
                    if (sin) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase

            if (w_data_store) begin
                if (r_byte_cnt < c_cnt_nb) begin
                    r_b <= w_b_shift[DATA_W-1:0];
                end else begin
                    r_a <= w_a_shift[DATA_W-1:0];
                end
                r_byte_cnt <= r_byte_cnt + c_cnt_one;
            end

            // Every packet boundary (good or bad) restarts counting and CRC.
            if (w_frame_err || w_extra || w_cmd_done) begin
                r_byte_cnt <= c_cnt_zero;
                r_crc      <= 4'd0;
            end

            if (w_extra) begin
                r_discard <= 1'b1;
            end else if (w_frame_err || w_cmd_done) begin
                r_discard <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // One-entry output register
    // ------------------------------------------------------------------
    // A slot is free when empty or when the held record leaves this cycle.
    assign w_load = w_rec_valid & (~r_out_valid | out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_b      <= '0;
            r_out_a      <= '0;
            r_out_op     <= 3'd0;
            r_out_is_err <= 1'b0;
            r_out_flags  <= c_flags_none;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= w_rec_valid & r_out_valid & ~out_ready;
            if (w_load) begin
                r_out_valid  <= 1'b1;
                r_out_b      <= r_b;
                r_out_a      <= r_a;
                r_out_op     <= w_cmd_op;
                r_out_is_err <= w_rec_is_err;
                r_out_flags  <= w_rec_flags;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign out_b         = r_out_b;
    assign out_a         = r_out_a;
    assign out_op        = r_out_op;
    assign out_is_err    = r_out_is_err;
    assign out_err_flags = r_out_flags;
    assign overrun       = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_mtm_alu_deser_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mtm_alu_deser_param
//  Purpose  : Scoreboard bench for mtm_alu_deser_param. Three instances
//             (DATA_W = 32, 16, 64) each have their own serial lane and
//             expectation queue; a monitor per instance pops and compares
//             on every output transfer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mtm_alu_deser_param;

    logic clk = 1'b0;
    logic rst;
    logic out_ready;
    logic rdy_hi;
    logic sin32, sin16, sin64;

    logic        v32, err32, ovr32;
    logic [31:0] b32, a32;
    logic [2:0]  op32;
    logic [5:0]  fl32;

    logic        v16, err16, ovr16;
    logic [15:0] b16, a16;
    logic [2:0]  op16;
    logic [5:0]  fl16;

    logic        v64, err64, ovr64;
    logic [63:0] b64, a64;
    logic [2:0]  op64;
    logic [5:0]  fl64;

    always #5 clk = ~clk;

    mtm_alu_deser_param #(.DATA_W(32), .VALID_OPS(8'b0011_0011)) u_dut (
        .clk(clk), .rst(rst), .sin(sin32), .out_valid(v32), .out_ready(out_ready),
        .out_b(b32), .out_a(a32), .out_op(op32), .out_is_err(err32),
        .out_err_flags(fl32), .overrun(ovr32)
    );

    mtm_alu_deser_param #(.DATA_W(16), .VALID_OPS(8'b0011_0011)) u_dut16 (
        .clk(clk), .rst(rst), .sin(sin16), .out_valid(v16), .out_ready(rdy_hi),
        .out_b(b16), .out_a(a16), .out_op(op16), .out_is_err(err16),
        .out_err_flags(fl16), .overrun(ovr16)
    );

    mtm_alu_deser_param #(.DATA_W(64), .VALID_OPS(8'b0011_0011)) u_dut64 (
        .clk(clk), .rst(rst), .sin(sin64), .out_valid(v64), .out_ready(rdy_hi),
        .out_b(b64), .out_a(a64), .out_op(op64), .out_is_err(err64),
        .out_err_flags(fl64), .overrun(ovr64)
    );

    typedef struct {
        int          id;
        logic        is_err;
        logic [5:0]  flags;
        logic [63:0] b;
        logic [63:0] a;
        logic [2:0]  op;
        int          cyc;   // required transfer cycle, -1 = any
    } exp_t;

    exp_t sb32[$];
    exp_t sb16[$];
    exp_t sb64[$];

    int n_cmp   = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ovr_cnt = 0;

    localparam logic [5:0] F_DATA = 6'b100100;
    localparam logic [5:0] F_CRC  = 6'b010010;
    localparam logic [5:0] F_OP   = 6'b001001;
    localparam logic [5:0] F_NONE = 6'b000000;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (ovr32) ovr_cnt++;

    // Reference CRC4, x^4 + x + 1, written as shift-then-conditional-XOR.
    function automatic logic [3:0] crc_ref_step(input logic [3:0] c, input logic d);
        logic [3:0] n;
        n = {c[2:0], 1'b0};
        if (c[3] ^ d) n = n ^ 4'b0011;
        return n;
    endfunction

    function automatic logic [3:0] crc_packet(input int nb, input logic [63:0] b,
                                              input logic [63:0] a, input logic [2:0] op);
        logic [3:0] c;
        c = 4'd0;
        for (int i = nb * 8 - 1; i >= 0; i--) c = crc_ref_step(c, b[i]);
        for (int i = nb * 8 - 1; i >= 0; i--) c = crc_ref_step(c, a[i]);
        c = crc_ref_step(c, 1'b1);
        for (int i = 2; i >= 0; i--) c = crc_ref_step(c, op[i]);
        return c;
    endfunction

    function automatic exp_t mk(input int id, input logic err, input logic [5:0] fl,
                                input logic [63:0] b, input logic [63:0] a,
                                input logic [2:0] op, input int c);
        exp_t e;
        e.id = id; e.is_err = err; e.flags = fl; e.b = b; e.a = a; e.op = op; e.cyc = c;
        return e;
    endfunction

    task automatic check_rec(input int lane, input exp_t e, input logic err,
                             input logic [5:0] fl, input logic [63:0] b,
                             input logic [63:0] a, input logic [2:0] op);
        bit ok;
        ok = (err === e.is_err) && (fl === e.flags);
        if (!e.is_err) ok = ok && (b === e.b) && (a === e.a) && (op === e.op);
        if (e.cyc >= 0) ok = ok && (cyc == e.cyc);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rec lane%0d id%0d: got err=%0b flags=%b b=%h a=%h op=%b cyc=%0d; required err=%0b flags=%b b=%h a=%h op=%b cyc=%0d",
                     lane, e.id, err, fl, b, a, op, cyc,
                     e.is_err, e.flags, e.b, e.a, e.op, e.cyc);
        end
    endtask

    task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] req);
        n_cmp++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, got, req);
        end
    endtask

    // ---------------- monitors ----------------
    exp_t m32, m16, m64;

    always @(negedge clk) begin
        if (!rst && v32 && out_ready) begin
            if (sb32.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected lane0: got flags=%b b=%h a=%h required no record", fl32, b32, a32);
            end else begin
                m32 = sb32.pop_front();
                check_rec(0, m32, err32, fl32, {32'd0, b32}, {32'd0, a32}, op32);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && v16) begin
            if (sb16.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected lane1: got flags=%b b=%h a=%h required no record", fl16, b16, a16);
            end else begin
                m16 = sb16.pop_front();
                check_rec(1, m16, err16, fl16, {48'd0, b16}, {48'd0, a16}, op16);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && v64) begin
            if (sb64.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected lane2: got flags=%b b=%h a=%h required no record", fl64, b64, a64);
            end else begin
                m64 = sb64.pop_front();
                check_rec(2, m64, err64, fl64, b64, a64, op64);
            end
        end
    end

    // ---------------- drivers ----------------
    // Every driver call leaves time at posedge + 1.
    task automatic drive(input int lane, input logic v);
        case (lane)
            0:       sin32 = v;
            1:       sin16 = v;
            default: sin64 = v;
        endcase
        @(posedge clk); #1;
    endtask

    task automatic idle(input int lane, input int n);
        for (int i = 0; i < n; i++) drive(lane, 1'b1);
    endtask

    task automatic send_frame(input int lane, input logic typ, input logic [7:0] by,
                              input logic stp);
        drive(lane, 1'b0);
        drive(lane, typ);
        for (int i = 7; i >= 0; i--) drive(lane, by[i]);
        drive(lane, stp);
    endtask

    function automatic logic [7:0] data_byte(input int nb, input int i,
                                             input logic [63:0] b, input logic [63:0] a);
        if (i < nb)     return b[8 * (nb - 1 - i) +: 8];
        if (i < 2 * nb) return a[8 * (2 * nb - 1 - i) +: 8];
        return 8'hA5;
    endfunction

    task automatic send_pkt(input int lane, input int nb, input int ndata,
                            input logic [63:0] b, input logic [63:0] a,
                            input logic [2:0] op, input logic [3:0] crc_x);
        logic [3:0] c;
        c = crc_packet(nb, b, a, op) ^ crc_x;
        for (int i = 0; i < ndata; i++) send_frame(lane, 1'b0, data_byte(nb, i, b, a), 1'b1);
        send_frame(lane, 1'b1, {1'b0, op, c}, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    int ovr0;
    int t0;

    initial begin
        rst = 1'b1; out_ready = 1'b1; rdy_hi = 1'b1;
        sin32 = 1'b1; sin16 = 1'b1; sin64 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cmp("reset_ab", {b32, a32}, 64'd0);
        cmp("reset_ctl", {52'd0, v32, op32, err32, fl32, ovr32}, 64'd0);
        rst = 1'b0;
        idle(0, 3);

        // Good packet, latency 99 cycles from the first start bit.
        sb32.push_back(mk(1, 1'b0, F_NONE, 64'h1, 64'h2, 3'b100, cyc + 99));
        send_pkt(0, 4, 8, 64'h1, 64'h2, 3'b100, 4'h0);
        idle(0, 3);

        sb32.push_back(mk(2, 1'b1, F_CRC, 0, 0, 0, -1));
        send_pkt(0, 4, 8, 64'h1, 64'h2, 3'b100, 4'h1);
        idle(0, 3);

        sb32.push_back(mk(3, 1'b1, F_OP, 0, 0, 0, -1));
        send_pkt(0, 4, 8, 64'h1, 64'h2, 3'b010, 4'h0);
        idle(0, 3);

        sb32.push_back(mk(4, 1'b1, F_CRC, 0, 0, 0, -1));
        send_pkt(0, 4, 8, 64'h1, 64'h2, 3'b010, 4'h1);
        idle(0, 3);

        // Short packet: error reported at the cmd stop bit.
        sb32.push_back(mk(5, 1'b1, F_DATA, 0, 0, 0, -1));
        send_pkt(0, 4, 7, 64'h1, 64'h2, 3'b100, 4'h0);
        idle(0, 3);

        // Long packet: error at the 9th stop bit, cmd swallowed; back-to-back frames.
        sb32.push_back(mk(6, 1'b1, F_DATA, 0, 0, 0, -1));
        send_pkt(0, 4, 9, 64'h1, 64'h2, 3'b100, 4'h0);
        idle(0, 3);

        sb32.push_back(mk(7, 1'b0, F_NONE, 64'hDEADBEEF, 64'h12345678, 3'b101, -1));
        send_pkt(0, 4, 8, 64'hDEADBEEF, 64'h12345678, 3'b101, 4'h0);
        idle(0, 3);

        // Framing error in data frame 3, line held low for 5 cycles.
        sb32.push_back(mk(8, 1'b1, F_DATA, 0, 0, 0, -1));
        send_frame(0, 1'b0, 8'h11, 1'b1);
        send_frame(0, 1'b0, 8'h22, 1'b1);
        send_frame(0, 1'b0, 8'h33, 1'b0);
        for (int i = 0; i < 4; i++) drive(0, 1'b0);
        idle(0, 5);

        sb32.push_back(mk(9, 1'b0, F_NONE, 64'h80000000, 64'hFFFFFFFF, 3'b001, -1));
        send_pkt(0, 4, 8, 64'h80000000, 64'hFFFFFFFF, 3'b001, 4'h0);
        idle(0, 3);

        // Reset while a record is held and a packet is half received.
        out_ready = 1'b0;
        send_pkt(0, 4, 8, 64'hCAFEF00D, 64'h0BADBEEF, 3'b000, 4'h0);
        idle(0, 2);
        cmp("held_before_rst", {31'd0, v32, b32}, {31'd0, 1'b1, 32'hCAFEF00D});
        send_frame(0, 1'b0, 8'h01, 1'b1);
        send_frame(0, 1'b0, 8'h02, 1'b1);
        drive(0, 1'b0);
        drive(0, 1'b0);
        #2 rst = 1'b1;
        #1;
        cmp("async_rst_ab", {b32, a32}, 64'd0);
        cmp("async_rst_ctl", {52'd0, v32, op32, err32, fl32, ovr32}, 64'd0);
        @(posedge clk); #1;
        sin32 = 1'b1;
        rst = 1'b0;
        out_ready = 1'b1;
        idle(0, 3);

        sb32.push_back(mk(10, 1'b0, F_NONE, 64'h0000FFFF, 64'hFFFF0000, 3'b100, -1));
        send_pkt(0, 4, 8, 64'h0000FFFF, 64'hFFFF0000, 3'b100, 4'h0);
        idle(0, 3);

        // Backpressure: second packet is dropped with one overrun pulse.
        out_ready = 1'b0;
        ovr0 = ovr_cnt;
        sb32.push_back(mk(11, 1'b0, F_NONE, 64'hA5A5A5A5, 64'h5A5A5A5A, 3'b100, -1));
        send_pkt(0, 4, 8, 64'hA5A5A5A5, 64'h5A5A5A5A, 3'b100, 4'h0);
        idle(0, 2);
        cmp("bp_hold1", {v32, op32, b32, a32[27:0]}, {1'b1, 3'b100, 32'hA5A5A5A5, 28'hA5A5A5A});
        send_pkt(0, 4, 8, 64'h11111111, 64'h22222222, 3'b101, 4'h0);
        idle(0, 2);
        cmp("bp_hold2", {v32, op32, b32, a32[27:0]}, {1'b1, 3'b100, 32'hA5A5A5A5, 28'hA5A5A5A});
        cmp("overrun_pulses", 64'(ovr_cnt - ovr0), 64'd1);
        out_ready = 1'b1;
        idle(0, 3);

        // Width regressions on the 16- and 64-bit instances.
        sb16.push_back(mk(12, 1'b0, F_NONE, 64'h0001, 64'h0002, 3'b100, cyc + 55));
        send_pkt(1, 2, 4, 64'h0001, 64'h0002, 3'b100, 4'h0);
        idle(1, 3);

        sb64.push_back(mk(13, 1'b0, F_NONE, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                          3'b101, cyc + 187));
        send_pkt(2, 8, 16, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 3'b101, 4'h0);
        idle(2, 3);

        t0 = 0;
        while ((sb32.size() + sb16.size() + sb64.size()) != 0 && t0 < 300) begin
            @(posedge clk); #1;
            t0++;
        end
        cmp("scoreboard_drained", 64'(sb32.size() + sb16.size() + sb64.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mtm_alu_deser_param.md
# mtm_alu_deser_param

Parametrised serial-frame deserializer for the mtm ALU. It receives 11-bit serial frames on `sin` and assembles operands B and A of `DATA_W` bits each, plus a command byte. It checks frame count, stop bits, CRC4 and opcode, then presents one result record to `mtm_Alu_core` over a ready/valid handshake. A one-entry output register decouples the serial stream from the core, and any overrun is reported.

## Interface
- `DATA_W`, 32: operand width; a multiple of 8 in the range 8..64. `NB = DATA_W/8` bytes per operand.
- `VALID_OPS`, 8'b0011_0011: legal-opcode mask. Bit *i* set means opcode *i* is legal. The default allows AND(000), OR(001), ADD(100) and SUB(101).
- `clk`  in  1  system clock, posedge active.
- `rst`  in  1  asynchronous reset, active-high.
- `sin`  in  1  serial input; idles high; one bit per `clk` cycle.
- `out_valid`  out  1  result record available.
- `out_ready`  in  1  core accepts the record.
- `out_b`, `out_a`  out  DATA_W  operands B and A.
- `out_op`  out  3  opcode.
- `out_is_err`  out  1  the record is an error report; operands are undefined.
- `out_err_flags`  out  6  error code: 100100 = DATA, 010010 = CRC, 001001 = OP; 000000 when there is no error.
- `overrun`  out  1  one-cycle pulse when a finished record is dropped because the output register is still full.

## Operation
- **Frame format:** start bit 0, type bit (0 = data, 1 = cmd), 8 payload bits MSB-first, stop bit 1.
- **Packet format:** 2·NB data frames, then one cmd frame.
  - Data bytes arrive B MSB-first first, then A MSB-first.
  - Cmd payload: bit 7 ignored, bits [6:4] = op, bits [3:0] = CRC.
- **State machine:** IDLE, TYPE, PAYLOAD, STOP, BREAK.
  - IDLE → TYPE when `sin`=0.
  - TYPE latches the type bit → PAYLOAD.
  - PAYLOAD runs 8 cycles, counted by a 3-bit counter → STOP.
  - STOP with `sin`=1 → IDLE.
  - STOP with `sin`=0 is a framing error → BREAK.
  - BREAK → IDLE when `sin`=1.
- **Data frame:** shift the byte into B while the byte count is below NB, otherwise into A. Byte count width is clog2(2·NB+2).
- **CRC4:** polynomial x⁴+x+1, initial value 0, computed serially as bits arrive. It covers the B and A bits, then a constant 1, then the 3 op bits.
- **End of cmd frame (valid stop bit):** check in this priority order:
  1. byte count ≠ 2·NB → DATA error;
  2. CRC mismatch → CRC error;
  3. `VALID_OPS[op]`=0 → OP error;
  4. otherwise a good record.
- **Extra data frame:** when a data frame finishes with byte count already at 2·NB, emit a DATA error immediately and set `discard`. Further data frames are ignored. The next cmd frame clears `discard` and emits nothing.
- **Framing error:** a stop bit of 0 emits a DATA error, clears the byte count, CRC and `discard`, and enters BREAK.
- **After any emitted record or framing error:** the byte count and CRC return to 0.
- **Output register:**
  - Loaded with a record when `out_valid`=0, or when `out_valid`=1 and `out_ready`=1 in the same cycle.
  - Otherwise the new record is dropped and `overrun` pulses for one cycle; the held record is unchanged.
  - `out_valid` clears when `out_ready`=1 and no new record arrives that cycle.
  - Outputs are stable while `out_valid`=1 and `out_ready`=0.

## Timing
- **Reset:** `rst` asynchronously forces state IDLE and clears all counters, CRC and `discard`. It also forces `out_valid`=0, `out_b`=`out_a`=0, `out_op`=0, `out_is_err`=0, `out_err_flags`=0 and `overrun`=0.
  - A reset mid-frame drops the partial packet.
  - After reset release, the first `sin`=0 is taken as a start bit.
- **Packet length:** 11·(2·NB+1) cycles; 99 cycles for `DATA_W`=32.
- **Result latency:** `out_valid` rises at the same posedge that samples the cmd stop bit, so it is visible in the cycle after the stop bit.
- **Error latency:** immediate error reports (extra frame, framing error) follow the same rule at their stop-bit edge.
- **Frame spacing:** back-to-back frames with zero idle cycles are supported; a start bit may immediately follow a stop bit.
- **Handshake:** a transfer occurs on a posedge with `out_valid`=`out_ready`=1. `out_ready` may be held high permanently.

## Test plan
- **Good packet:** `DATA_W`=32, B=0x00000001, A=0x00000002, op=100, model-computed CRC → one record with out_b=0x1, out_a=0x2, out_op=100, out_is_err=0, flags=000000, 99 cycles after the first start bit.
- **CRC error:** same packet with the CRC XOR 4'h1 → out_is_err=1, flags=010010.
- **OP error:** op=010 with correct CRC → flags=001001. Repeat with a CRC error as well → flags=010010 (CRC has priority).
- **Frame-count errors:**
  - 7 data frames + cmd → flags=100100 at the cmd stop bit.
  - 9 data frames + cmd → flags=100100 at the 9th frame's stop bit, and nothing for the cmd.
  - A following good packet decodes correctly.
- **Framing error and reset:**
  - Stop bit = 0 in data frame 3 with `sin` held low 5 cycles → flags=100100 immediately, then a clean good packet decodes.
  - `rst` pulsed mid-packet → all outputs 0, and the next good packet decodes.
- **Backpressure:** `out_ready`=0 across two good packets → the first record is held unchanged and `overrun` pulses once at the second cmd stop bit. `DATA_W`=16 and `DATA_W`=64 regressions rerun the good-packet case with NB-scaled frame counts.
